// File: rtl/ex_alu_ctrl.sv
// ex_alu_ctrl: execute-stage controller for the 16-bit ALU.
//
// Holds one instruction in the EX register, drives the ALU operands and
// one-hot operation selects from it, captures the result into the EX/MEM
// output register and owns the architectural {O,N,Z} condition code register.
// Both sides use valid/ready handshakes; flush kills the EX register entry.
//
// Ports:
//   clk, rst                     rising-edge clock, synchronous active-low reset
//   in_valid/in_ready            decode-side handshake
//   in_op/src/dst/imm/rd         instruction fields from decode
//   flush                        drop the instruction held in EX
//   alu_src/dst/imm              operands to the ALU (EX register contents)
//   alu_add/not/ldm              ALU operation selects (one-hot or zero)
//   alu_result, alu_ccr          combinational ALU outputs
//   out_valid/out_ready          memory-side handshake
//   out_result, out_rd, out_wb   registered result, destination, write enable
//   ccr                          architectural flags {O,N,Z}
//   busy                         EX or output register occupied
module ex_alu_ctrl #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned RD_W  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_src,
    input  logic [WIDTH-1:0] in_dst,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [RD_W-1:0]  in_rd,
    input  logic             flush,
    output logic [WIDTH-1:0] alu_src,
    output logic [WIDTH-1:0] alu_dst,
    output logic [WIDTH-1:0] alu_imm,
    output logic             alu_add,
    output logic             alu_not,
    output logic             alu_ldm,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [2:0]       alu_ccr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [RD_W-1:0]  out_rd,
    output logic             out_wb,
    output logic [2:0]       ccr,
    output logic             busy
);

    localparam logic [2:0] OpAdd  = 3'b001;
    localparam logic [2:0] OpNot  = 3'b010;
    localparam logic [2:0] OpLdm  = 3'b011;
    localparam logic [2:0] OpClrf = 3'b100;
    localparam logic [2:0] OpMov  = 3'b101;

    // EX register
    logic             ex_valid_q, ex_valid_d;
    logic [2:0]       ex_op_q, ex_op_d;
    logic [WIDTH-1:0] ex_src_q, ex_src_d;
    logic [WIDTH-1:0] ex_dst_q, ex_dst_d;
    logic [WIDTH-1:0] ex_imm_q, ex_imm_d;
    logic [RD_W-1:0]  ex_rd_q, ex_rd_d;

    // EX/MEM output register and flags
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic [RD_W-1:0]  out_rd_q, out_rd_d;
    logic             out_wb_q, out_wb_d;
    logic [2:0]       ccr_q, ccr_d;

    logic op_real;
    logic adv;
    logic acc;

    // NOP and the reserved encodings are consumed but never occupy EX.
    always_comb begin
        op_real = 1'b0;
        case (in_op)
            OpAdd, OpNot, OpLdm, OpClrf, OpMov: op_real = 1'b1;
            default:                            op_real = 1'b0;
        endcase
    end

    assign adv      = ex_valid_q & ~flush & (~out_valid_q | out_ready);
    assign in_ready = ~ex_valid_q | adv;
    assign acc      = in_valid & in_ready & ~flush & op_real;

    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_op_d      = ex_op_q;
        ex_src_d     = ex_src_q;
        ex_dst_d     = ex_dst_q;
        ex_imm_d     = ex_imm_q;
        ex_rd_d      = ex_rd_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_rd_d     = out_rd_q;
        out_wb_d     = out_wb_q;
        ccr_d        = ccr_q;

        // A new instruction refills EX even while the old one advances.
        if (acc) begin
            ex_valid_d = 1'b1;
            ex_op_d    = in_op;
            ex_src_d   = in_src;
            ex_dst_d   = in_dst;
            ex_imm_d   = in_imm;
            ex_rd_d    = in_rd;
        end else if (adv || flush) begin
            ex_valid_d = 1'b0;
        end

        if (adv) begin
            out_valid_d = 1'b1;
            out_rd_d    = ex_rd_q;
            case (ex_op_q)
                OpAdd, OpNot, OpLdm: begin
                    out_result_d = alu_result;
                    out_wb_d     = 1'b1;
                end
                OpMov: begin
                    out_result_d = ex_src_q;
                    out_wb_d     = 1'b1;
                end
                default: begin
                    out_result_d = '0;
                    out_wb_d     = 1'b0;
                end
            endcase

            // Only committed instructions touch the flags; NOT never sets O.
            case (ex_op_q)
                OpAdd:   ccr_d = alu_ccr;
                OpNot:   ccr_d = {1'b0, alu_ccr[1:0]};
                OpClrf:  ccr_d = 3'b000;
                default: ccr_d = ccr_q;
            endcase
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_valid_q   <= 1'b0;
            ex_op_q      <= 3'b000;
            ex_src_q     <= '0;
            ex_dst_q     <= '0;
            ex_imm_q     <= '0;
            ex_rd_q      <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_rd_q     <= '0;
            out_wb_q     <= 1'b0;
            ccr_q        <= 3'b000;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_op_q      <= ex_op_d;
            ex_src_q     <= ex_src_d;
            ex_dst_q     <= ex_dst_d;
            ex_imm_q     <= ex_imm_d;
            ex_rd_q      <= ex_rd_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_rd_q     <= out_rd_d;
            out_wb_q     <= out_wb_d;
            ccr_q        <= ccr_d;
        end
    end

    assign alu_src = ex_src_q;
    assign alu_dst = ex_dst_q;
    assign alu_imm = ex_imm_q;
    assign alu_add = ex_valid_q && (ex_op_q == OpAdd);
    assign alu_not = ex_valid_q && (ex_op_q == OpNot);
    assign alu_ldm = ex_valid_q && (ex_op_q == OpLdm);

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_rd     = out_rd_q;
    assign out_wb     = out_wb_q;
    assign ccr        = ccr_q;
    assign busy       = ex_valid_q | out_valid_q;

endmodule

// File: tb/tb_ex_alu_ctrl.sv
// Testbench for ex_alu_ctrl: a behavioural ALU answers the controller's
// selects; a table of single instructions plus hand-written sequences for
// back-to-back issue, stall, flush, reserved opcodes and reset.
module tb_ex_alu_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [15:0] in_src;
    logic [15:0] in_dst;
    logic [15:0] in_imm;
    logic [2:0]  in_rd;
    logic        flush;
    logic [15:0] alu_src;
    logic [15:0] alu_dst;
    logic [15:0] alu_imm;
    logic        alu_add;
    logic        alu_not;
    logic        alu_ldm;
    logic [15:0] alu_result;
    logic [2:0]  alu_ccr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [2:0]  out_rd;
    logic        out_wb;
    logic [2:0]  ccr;
    logic        busy;

    int total = 0;
    int bad   = 0;

    ex_alu_ctrl #(.WIDTH(16), .RD_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_src     (in_src),
        .in_dst     (in_dst),
        .in_imm     (in_imm),
        .in_rd      (in_rd),
        .flush      (flush),
        .alu_src    (alu_src),
        .alu_dst    (alu_dst),
        .alu_imm    (alu_imm),
        .alu_add    (alu_add),
        .alu_not    (alu_not),
        .alu_ldm    (alu_ldm),
        .alu_result (alu_result),
        .alu_ccr    (alu_ccr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_wb     (out_wb),
        .ccr        (ccr),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU. O is forced high for NOT/LDM and junk is driven when
    // idle so the controller's masking and MOV bypass are exercised.
    logic [15:0] sum;
    always_comb begin
        sum        = alu_src + alu_dst;
        alu_result = 16'hDEAD;
        alu_ccr    = 3'b111;
        if (alu_add) begin
            alu_result = sum;
            alu_ccr    = {(alu_src[15] == alu_dst[15]) && (sum[15] != alu_src[15]),
                          sum[15], sum == 16'h0000};
        end else if (alu_not) begin
            alu_result = ~alu_dst;
            alu_ccr    = {1'b1, ~alu_dst[15], ~alu_dst == 16'h0000};
        end else if (alu_ldm) begin
            alu_result = alu_imm;
            alu_ccr    = 3'b111;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [15:0] s, input logic [15:0] d,
                         input logic [15:0] i, input logic [2:0] rd);
        in_valid = 1'b1;
        in_op    = op;
        in_src   = s;
        in_dst   = d;
        in_imm   = i;
        in_rd    = rd;
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_op    = 3'b000;
        #1;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] imm;
        logic [2:0]  rd;
        logic [2:0]  sel;   // {add, not, ldm}
        logic [15:0] res;
        logic        wb;
        logic [2:0]  ccr;   // flags after commit
    } vec_t;

    vec_t vec [9];

    initial begin
        vec[0] = '{3'b001, 16'h7FFF, 16'h0001, 16'h0000, 3'd1, 3'b100, 16'h8000, 1'b1, 3'b110};
        vec[1] = '{3'b001, 16'h0001, 16'hFFFF, 16'h0000, 3'd2, 3'b100, 16'h0000, 1'b1, 3'b001};
        vec[2] = '{3'b011, 16'h5555, 16'h6666, 16'h1234, 3'd3, 3'b001, 16'h1234, 1'b1, 3'b001};
        vec[3] = '{3'b010, 16'h0000, 16'h00FF, 16'h0000, 3'd4, 3'b010, 16'hFF00, 1'b1, 3'b010};
        vec[4] = '{3'b101, 16'h00AA, 16'h1111, 16'h2222, 3'd5, 3'b000, 16'h00AA, 1'b1, 3'b010};
        vec[5] = '{3'b001, 16'h8000, 16'h8000, 16'h0000, 3'd6, 3'b100, 16'h0000, 1'b1, 3'b101};
        vec[6] = '{3'b010, 16'h0000, 16'h0000, 16'h0000, 3'd7, 3'b010, 16'hFFFF, 1'b1, 3'b010};
        vec[7] = '{3'b100, 16'h1234, 16'h5678, 16'h9ABC, 3'd3, 3'b000, 16'h0000, 1'b0, 3'b000};
        vec[8] = '{3'b001, 16'hFFFF, 16'hFFFE, 16'h0000, 3'd0, 3'b100, 16'hFFFD, 1'b1, 3'b010};

        rst       = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        in_op     = 3'b000;
        in_src    = '0;
        in_dst    = '0;
        in_imm    = '0;
        in_rd     = '0;

        // Reset held for two edges while an instruction is offered.
        drive(3'b001, 16'h7FFF, 16'h0001, 16'h0000, 3'd1);
        tick();
        tick();
        rst = 1'b1;
        idle();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ccr", ccr, 3'b000);
        chk("rst_busy", busy, 0);
        chk("rst_out_result", out_result, 16'h0000);
        chk("rst_out_wb", out_wb, 0);

        // Single instructions with out_ready=1.
        for (int k = 0; k < 9; k++) begin
            drive(vec[k].op, vec[k].src, vec[k].dst, vec[k].imm, vec[k].rd);
            chk($sformatf("v%0d_in_ready", k), in_ready, 1);
            tick();
            idle();
            chk($sformatf("v%0d_sel", k), {alu_add, alu_not, alu_ldm}, vec[k].sel);
            chk($sformatf("v%0d_alu_src", k), alu_src, vec[k].src);
            tick();
            chk($sformatf("v%0d_out_valid", k), out_valid, 1);
            chk($sformatf("v%0d_result", k), out_result, vec[k].res);
            chk($sformatf("v%0d_wb", k), out_wb, vec[k].wb);
            chk($sformatf("v%0d_rd", k), out_rd, vec[k].rd);
            chk($sformatf("v%0d_ccr", k), ccr, vec[k].ccr);
            tick();
            chk($sformatf("v%0d_drained", k), out_valid, 0);
        end

        // Back-to-back NOT then LDM: results on consecutive cycles, LDM keeps flags.
        drive(3'b010, 16'h0000, 16'hFFFF, 16'h0000, 3'd1);
        tick();
        drive(3'b011, 16'h0000, 16'h0000, 16'h1234, 3'd2);
        tick();
        idle();
        chk("b2b_not_valid", out_valid, 1);
        chk("b2b_not_result", out_result, 16'h0000);
        chk("b2b_not_ccr", ccr, 3'b001);
        tick();
        chk("b2b_ldm_valid", out_valid, 1);
        chk("b2b_ldm_result", out_result, 16'h1234);
        chk("b2b_ldm_rd", out_rd, 3'd2);
        chk("b2b_ldm_ccr", ccr, 3'b001);
        tick();

        // Stall: two ADDs fit, the third is refused until the output drains.
        out_ready = 1'b0;
        drive(3'b001, 16'h0010, 16'h0001, 16'h0000, 3'd1);
        chk("stall_rdy1", in_ready, 1);
        tick();
        drive(3'b001, 16'h0020, 16'h0002, 16'h0000, 3'd2);
        chk("stall_rdy2", in_ready, 1);
        tick();
        drive(3'b001, 16'h0030, 16'h0003, 16'h0000, 3'd3);
        chk("stall_rdy3", in_ready, 0);
        chk("stall_hold1_result", out_result, 16'h0011);
        tick();
        chk("stall_rdy3_again", in_ready, 0);
        chk("stall_hold2_result", out_result, 16'h0011);
        chk("stall_hold_rd", out_rd, 3'd1);
        chk("stall_busy", busy, 1);
        idle();
        out_ready = 1'b1;
        tick();
        chk("drain_valid2", out_valid, 1);
        chk("drain_result2", out_result, 16'h0022);
        chk("drain_rd2", out_rd, 3'd2);
        tick();
        chk("drain_empty", out_valid, 0);
        chk("drain_busy", busy, 0);
        chk("drain_ccr", ccr, 3'b000);

        // Flush kills the ADD in EX and blocks the concurrent MOV.
        drive(3'b001, 16'h7FFF, 16'h0001, 16'h0000, 3'd4);
        tick();
        flush = 1'b1;
        drive(3'b101, 16'h00AA, 16'h0000, 16'h0000, 3'd5);
        chk("flush_alu_add", alu_add, 1);
        tick();
        flush = 1'b0;
        idle();
        chk("flush_out_valid", out_valid, 0);
        chk("flush_busy", busy, 0);
        chk("flush_ccr", ccr, 3'b000);
        tick();
        chk("flush_out_valid2", out_valid, 0);
        drive(3'b101, 16'h00AA, 16'h0000, 16'h0000, 3'd5);
        tick();
        idle();
        tick();
        chk("mov_valid", out_valid, 1);
        chk("mov_result", out_result, 16'h00AA);
        chk("mov_wb", out_wb, 1);
        chk("mov_rd", out_rd, 3'd5);
        chk("mov_ccr", ccr, 3'b000);
        tick();

        // Reserved opcodes and NOP are consumed without effect; CLRF clears flags.
        drive(3'b001, 16'h7FFF, 16'h0001, 16'h0000, 3'd6);
        tick();
        idle();
        tick();
        chk("pre_clrf_ccr", ccr, 3'b110);
        tick();
        for (int k = 0; k < 3; k++) begin
            logic [2:0] rop;
            rop = (k == 0) ? 3'b111 : (k == 1) ? 3'b110 : 3'b000;
            drive(rop, 16'h1111, 16'h2222, 16'h3333, 3'd7);
            chk($sformatf("rsv%0d_in_ready", k), in_ready, 1);
            tick();
            idle();
            chk($sformatf("rsv%0d_busy", k), busy, 0);
            tick();
            chk($sformatf("rsv%0d_out_valid", k), out_valid, 0);
            chk($sformatf("rsv%0d_ccr", k), ccr, 3'b110);
        end
        drive(3'b100, 16'h1111, 16'h2222, 16'h3333, 3'd7);
        tick();
        idle();
        tick();
        chk("clrf_valid", out_valid, 1);
        chk("clrf_wb", out_wb, 0);
        chk("clrf_result", out_result, 16'h0000);
        chk("clrf_ccr", ccr, 3'b000);
        tick();

        // Reset mid-operation drops the in-flight ADD without a flag update.
        drive(3'b001, 16'h7FFF, 16'h0001, 16'h0000, 3'd1);
        tick();
        idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        tick();
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_ccr", ccr, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
